// File: rtl/aes_pkg.sv
// Shared AES datapath types and helpers.
//   BLOCK_BYTES       : bytes per 128-bit cipher state
//   state_t / byte_t  : state and byte types; byte i = state[127-8i -: 8], i = row + 4*col
//   sub_bytes_state_t : SubBytes stage FSM states
//   shift_rows()      : FIPS-197 ShiftRows permutation (pure wiring)
package aes_pkg;

    localparam int unsigned BLOCK_BYTES = 16;

    typedef logic [127:0] state_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } sub_bytes_state_t;

    // Output byte (r + 4c) takes input byte (r + 4*((c + r) mod 4)): row r rotates left by r.
    function automatic state_t shift_rows(input state_t s);
        state_t res;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                res[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/s_box_lookup.sv
// AES forward S-box, purely combinational.
// The multiplicative inverse in GF(2^8) is formed as x^254 by an addition chain,
// followed by the FIPS-197 affine transform.
//   in_byte  : byte to substitute
//   out_byte : S-box image of in_byte
module s_box_lookup
    import aes_pkg::*;
(
    input  byte_t in_byte,
    output byte_t out_byte
);

    // Multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0, and 0 maps to 0 as the S-box requires.
    function automatic byte_t gf_inv(input byte_t x);
        byte_t x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        return gf_mul(x127, x127);
    endfunction

    byte_t inv;

    assign inv      = gf_inv(in_byte);
    assign out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/sub_bytes_stage.sv
// AES SubBytes round stage with valid/ready handshake on both sides.
// Accepts one 128-bit state, substitutes LANES bytes per cycle over 16/LANES cycles,
// then holds the result until downstream accepts it.
// Build option: define SUB_BYTES_SHIFT_ROWS_EN to apply ShiftRows to out_state.
//   clk, n_rst          : clock, asynchronous active-low reset
//   clear               : synchronous abort back to IDLE
//   in_valid/in_ready   : input handshake, in_state is the offered state
//   out_valid/out_ready : output handshake, out_state is the held result
//   busy                : high while substituting or holding a result
module sub_bytes_stage
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic   clk,
    input  logic   n_rst,
    input  logic   clear,
    input  logic   in_valid,
    output logic   in_ready,
    input  state_t in_state,
    output logic   out_valid,
    input  logic   out_ready,
    output state_t out_state,
    output logic   busy
);

    localparam int unsigned CHUNKS = BLOCK_BYTES / LANES;
    // Keep the counter at least one bit wide; for LANES=16 it just stays 0.
    localparam int unsigned CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_stage: LANES must be 1, 2, 4, 8 or 16");
    end

    sub_bytes_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           buf_q, buf_d;

    byte_t      buf_bytes [BLOCK_BYTES];
    byte_t      nxt_bytes [BLOCK_BYTES];
    state_t     sub_state;
    logic [3:0] base;
    byte_t      lane_in  [LANES];
    byte_t      lane_out [LANES];

    always_comb begin
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            buf_bytes[i] = buf_q[127 - 8 * i -: 8];
        end
    end

    // First byte of the chunk handled this cycle.
    assign base = 4'(cnt_q * LANES);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_in[k] = buf_bytes[base + 4'(k)];

        s_box_lookup u_s_box (
            .in_byte  (lane_in[k]),
            .out_byte (lane_out[k])
        );
    end

    // Buffer with the current chunk replaced by its S-box images.
    always_comb begin
        sub_state = '0;
        nxt_bytes = buf_bytes;
        for (int k = 0; k < LANES; k++) begin
            nxt_bytes[base + 4'(k)] = lane_out[k];
        end
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            sub_state[127 - 8 * i -: 8] = nxt_bytes[i];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        unique case (state_q)
            IDLE: begin
                if (!clear && in_valid) begin
                    buf_d   = in_state;
                    cnt_d   = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                if (clear) begin
                    state_d = IDLE;
                end else begin
                    buf_d = sub_state;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (clear || out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

`ifdef SUB_BYTES_SHIFT_ROWS_EN
    assign out_state = shift_rows(buf_q);
`else
    assign out_state = buf_q;
`endif

endmodule

// File: tb/tb_sub_bytes_stage.sv
module tb_sub_bytes_stage;

    localparam int NDUT = 5;  // LANES = 1, 2, 4, 8, 16

    logic clk = 1'b0;
    logic n_rst;
    logic clear;
    logic in_valid;
    logic out_ready;
    logic [127:0] in_state;

    logic [NDUT-1:0] in_ready_v;
    logic [NDUT-1:0] out_valid_v;
    logic [NDUT-1:0] busy_v;
    logic [127:0]    out_state_a [NDUT];

    int checks   = 0;
    int failures = 0;

    logic [7:0] sbox_tab [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sub_bytes_stage #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .n_rst     (n_rst),
            .clear     (clear),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[g]),
            .in_state  (in_state),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .out_state (out_state_a[g]),
            .busy      (busy_v[g])
        );
    end

    // Reference GF(2^8) product: carry-less multiply, then reduce by 0x11b.
    function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    // S-box from its definition: brute-force inverse, then affine map bit by bit.
    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        inv = 8'h00;
        c   = 8'h63;
        if (x != 0) begin
            for (int y = 1; y < 256; y++) if (ref_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                 ^ inv[(i + 7) % 8] ^ c[i];
        end
        return s;
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] s);
        logic [7:0]   m [4][4];  // [row][col]
        logic [7:0]   t [4];
        logic [127:0] res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = sbox_tab[s[127 - 8 * (r + 4 * c) -: 8]];
`ifdef SUB_BYTES_SHIFT_ROWS_EN
        for (int r = 1; r < 4; r++) begin
            for (int n = 0; n < r; n++) begin
                t[0] = m[r][0];
                m[r][0] = m[r][1];
                m[r][1] = m[r][2];
                m[r][2] = m[r][3];
                m[r][3] = t[0];
            end
        end
`else
        t[0] = 8'h00;
        if (t[0] != 8'h00) m[0][0] = t[0];
`endif
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8 * (r + 4 * c) -: 8] = m[r][c];
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer s at one edge, hold out_ready low for 20 cycles (backpressure), then release.
    task automatic run_txn(input string name, input logic [127:0] s, input logic [127:0] exp);
        int           lat    [NDUT];
        logic [127:0] first  [NDUT];
        bit           stable [NDUT];
        bit           rdy_busy;
        in_state  = s;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_state = ~s;  // keeps offering other data while busy; must be ignored
        rdy_busy = (in_ready_v != '0);
        for (int g = 0; g < NDUT; g++) begin
            lat[g]    = 0;
            first[g]  = '0;
            stable[g] = 1'b1;
        end
        for (int cyc = 1; cyc <= 20; cyc++) begin
            step();
            if (in_ready_v != '0) rdy_busy = 1'b1;
            for (int g = 0; g < NDUT; g++) begin
                if (lat[g] != 0) begin
                    if (!out_valid_v[g] || out_state_a[g] !== first[g]) stable[g] = 1'b0;
                end else if (out_valid_v[g]) begin
                    lat[g]   = cyc;
                    first[g] = out_state_a[g];
                end
            end
        end
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s_lat_L%0d", name, 1 << g), 128'(lat[g]), 128'(16 >> g));
            check($sformatf("%s_data_L%0d", name, 1 << g), out_state_a[g], exp);
            check($sformatf("%s_hold_L%0d", name, 1 << g), 128'({stable[g], out_valid_v[g]}),
                  128'(2'b11));
        end
        check({name, "_in_ready_busy"}, 128'(rdy_busy), 128'(0));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_release_ready"}, 128'(in_ready_v), 128'(5'h1f));
        check({name, "_release_valid"}, 128'({out_valid_v, busy_v}), 128'(0));
    endtask

    initial begin
        logic [127:0] rs;
        bit           seen_valid;

        for (int i = 0; i < 256; i++) sbox_tab[i] = ref_sbox(8'(i));

        n_rst     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_state  = '0;
        #12;
        check("rst_in_ready", 128'(in_ready_v), 128'(5'h1f));
        check("rst_valid_busy", 128'({out_valid_v, busy_v}), 128'(0));
        check("rst_out_state_L4", out_state_a[2], 128'h0);
        n_rst = 1'b1;
        step();

        // Directed vectors with known answers.
        run_txn("zero", 128'h0, {16{8'h63}});
`ifdef SUB_BYTES_SHIFT_ROWS_EN
        run_txn("seq", 128'h000102030405060708090a0b0c0d0e0f,
                128'h636b6776f201ab7b30d777c5fe7c6f2b);
`else
        run_txn("seq", 128'h000102030405060708090a0b0c0d0e0f,
                128'h637c777bf26b6fc53001672bfed7ab76);
`endif
        run_txn("ones", {16{8'hff}}, {16{8'h16}});

        // Reset in the middle of SUB.
        in_state = 128'h0123456789abcdeffedcba9876543210;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        n_rst = 1'b0;
        #1;
        check("midrst_in_ready", 128'(in_ready_v), 128'(5'h1f));
        check("midrst_valid_busy", 128'({out_valid_v, busy_v}), 128'(0));
        for (int g = 0; g < NDUT; g++)
            check($sformatf("midrst_out_state_L%0d", 1 << g), out_state_a[g], 128'h0);
        #1;
        n_rst = 1'b1;
        step();
        run_txn("post_rst", 128'h00112233445566778899aabbccddeeff,
                ref_model(128'h00112233445566778899aabbccddeeff));

        // clear on the second SUB cycle.
        in_state = {4{32'hdeadbeef}};
        in_valid = 1'b1;
        step();
        in_valid   = 1'b0;
        seen_valid = (out_valid_v[3:0] != '0);
        step();
        if (out_valid_v[3:0] != '0) seen_valid = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_idle_busy", 128'(busy_v), 128'(0));
        check("clear_idle_ready", 128'(in_ready_v), 128'(5'h1f));
        check("clear_no_valid", 128'({seen_valid, out_valid_v}), 128'(0));
        step();
        check("clear_stays_idle", 128'(busy_v), 128'(0));
        run_txn("after_clear", {16{8'h53}}, {16{8'hed}});

        // clear in IDLE blocks a simultaneous offer.
        clear    = 1'b1;
        in_valid = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_blocks_accept", 128'(busy_v), 128'(0));

        // Random states against the reference model.
        for (int n = 0; n < 6; n++) begin
            rs = {$urandom, $urandom, $urandom, $urandom};
            run_txn($sformatf("rand%0d", n), rs, ref_model(rs));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
